// File: rtl/avg_event_detector.sv
// avg_event_detector
// Watches averaged per-axis window sums (x, y, t) and raises a one-cycle
// event strobe once ARM_COUNT consecutive accepted samples each have at
// least one axis at or above thr_hi. After a trigger the block sits in a
// holdoff period of HOLDOFF_CYCLES clocks, then waits for a quiet sample
// (all axes below thr_lo) before it re-arms.
//
// Build option: define AVG_EVT_COUNT_SAT_EN to make event_count saturate
// at 255. Without it, event_count wraps from 255 to 0.
module avg_event_detector #(
    parameter int unsigned ARM_COUNT      = 3,
    parameter int unsigned HOLDOFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_x,
    input  logic [1:0] in_y,
    input  logic [1:0] in_t,
    input  logic [1:0] thr_hi,
    input  logic [1:0] thr_lo,
    output logic       event_pulse,
    output logic [2:0] event_axis,
    output logic [7:0] event_count,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ARMING    = 2'b01,
        S_TRIGGERED = 2'b10,
        S_HOLDOFF   = 2'b11
    } state_t;

    localparam logic [3:0] ARM_TARGET = 4'(ARM_COUNT);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLDOFF_CYCLES);

    state_t     state_q,     state_d;
    logic [3:0] arm_cnt_q,   arm_cnt_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [2:0] axis_q,      axis_d;
    logic [7:0] count_q,     count_d;
    logic       pulse_q,     pulse_d;
    logic       ready_q,     ready_d;

    logic       accept_s;
    logic [2:0] mask_s;
    logic       active_s;
    logic       quiet_s;
    logic [3:0] arm_inc_s;

    // Next value of the trigger counter; wrap or saturate depending on build.
    function automatic logic [7:0] count_next(input logic [7:0] cur);
`ifdef AVG_EVT_COUNT_SAT_EN
        if (cur == 8'hFF) begin
            return 8'hFF;
        end else begin
            return cur + 8'd1;
        end
`else
        return cur + 8'd1;
`endif
    endfunction

    // Classify the presented sample against the live thresholds.
    always_comb begin
        accept_s  = in_valid & ready_q;
        mask_s    = {(in_t >= thr_hi), (in_y >= thr_hi), (in_x >= thr_hi)};
        active_s  = accept_s & (|mask_s);
        quiet_s   = accept_s & (in_x < thr_lo) & (in_y < thr_lo) & (in_t < thr_lo);
        arm_inc_s = arm_cnt_q + 4'd1;
    end

    // Next-state and next-output computation for the detector.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        hold_cnt_d = hold_cnt_q;
        axis_d     = axis_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE, S_ARMING: begin
                if (active_s) begin
                    if (arm_inc_s == ARM_TARGET) begin
                        // Completing sample: latch its mask and start holdoff.
                        state_d    = S_TRIGGERED;
                        axis_d     = mask_s;
                        count_d    = count_next(count_q);
                        hold_cnt_d = HOLD_LOAD;
                        arm_cnt_d  = 4'd0;
                    end else begin
                        state_d   = S_ARMING;
                        arm_cnt_d = arm_inc_s;
                    end
                end else if (accept_s) begin
                    // A non-active sample breaks the streak.
                    state_d   = S_IDLE;
                    arm_cnt_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_TRIGGERED: begin
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (hold_cnt_q != 8'd0) begin
                    // Samples are ignored until the holdoff timer runs out.
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else if (quiet_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arm_cnt_d = 4'd0;
            end
        endcase
        pulse_d = (state_d == S_TRIGGERED);
        ready_d = (state_d != S_TRIGGERED);
    end

    // State and registered outputs; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            arm_cnt_q  <= 4'd0;
            hold_cnt_q <= 8'd0;
            axis_q     <= 3'b000;
            count_q    <= 8'd0;
            pulse_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            axis_q     <= axis_d;
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            ready_q    <= ready_d;
        end
    end

    assign in_ready    = ready_q;
    assign event_pulse = pulse_q;
    assign event_axis  = axis_q;
    assign event_count = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_avg_event_detector.sv
// Bench for avg_event_detector: two instances (default parameters, and
// ARM_COUNT=1 / HOLDOFF_CYCLES=2) share one directed stimulus stream. A
// behavioural model tracks the run of active samples and the number of
// edges since the last trigger, and its outputs are compared every cycle.
module tb_avg_event_detector;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_x     = 2'd0;
    logic [1:0] in_y     = 2'd0;
    logic [1:0] in_t     = 2'd0;
    logic [1:0] thr_hi   = 2'd2;
    logic [1:0] thr_lo   = 2'd1;

    logic       a_ready, a_pulse, b_ready, b_pulse;
    logic [2:0] a_axis, b_axis;
    logic [7:0] a_count, b_count;
    logic [1:0] a_state, b_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avg_event_detector #(.ARM_COUNT(3), .HOLDOFF_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ready),
        .in_x(in_x), .in_y(in_y), .in_t(in_t), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .event_pulse(a_pulse), .event_axis(a_axis), .event_count(a_count),
        .state_o(a_state)
    );

    avg_event_detector #(.ARM_COUNT(1), .HOLDOFF_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ready),
        .in_x(in_x), .in_y(in_y), .in_t(in_t), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .event_pulse(b_pulse), .event_axis(b_axis), .event_count(b_count),
        .state_o(b_state)
    );

    // Model: st is the visible state, run the current streak of active
    // accepted samples, since the number of edges after the last trigger,
    // trig the total number of triggers (unbounded integer).
    typedef struct {
        logic [1:0] st;
        int         run;
        int         since;
        logic [2:0] axis;
        int         trig;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, int arm_n, int hold_n, logic rst, logic v,
                                   logic [1:0] x, logic [1:0] y, logic [1:0] t,
                                   logic [1:0] hi, logic [1:0] lo);
        mdl_t n;
        logic acc, quiet;
        logic [2:0] mask;
        n = m;
        if (rst) begin
            n.st = 2'b00; n.run = 0; n.since = 0; n.axis = 3'b000; n.trig = 0;
            return n;
        end
        acc   = v && (m.st != 2'b10);
        mask  = {t >= hi, y >= hi, x >= hi};
        quiet = acc && (x < lo) && (y < lo) && (t < lo);
        if (m.since < 1000000) n.since = m.since + 1;
        case (m.st)
            2'b10: n.st = 2'b11;
            2'b11: begin
                // The k-th edge after a trigger may release once k >= HOLDOFF+2.
                if (quiet && (m.since + 1 >= hold_n + 2)) n.st = 2'b00;
            end
            default: begin
                if (acc && (mask != 3'b000)) begin
                    n.run = m.run + 1;
                    if (n.run == arm_n) begin
                        n.st = 2'b10; n.axis = mask; n.trig = m.trig + 1;
                        n.since = 0; n.run = 0;
                    end else begin
                        n.st = 2'b01;
                    end
                end else if (acc) begin
                    n.run = 0; n.st = 2'b00;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [7:0] exp_count(int trig);
`ifdef AVG_EVT_COUNT_SAT_EN
        return (trig > 255) ? 8'd255 : 8'(trig);
`else
        return 8'(trig % 256);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance both models on every rising edge using the applied inputs.
    always @(posedge clk) begin
        ma <= mstep(ma, 3, 8, reset, in_valid, in_x, in_y, in_t, thr_hi, thr_lo);
        mb <= mstep(mb, 1, 2, reset, in_valid, in_x, in_y, in_t, thr_hi, thr_lo);
    end

    // Compare both instances against their models on every falling edge.
    always @(negedge clk) begin
        check("a_state", 32'(a_state), 32'(ma.st));
        check("a_pulse", 32'(a_pulse), 32'(ma.st == 2'b10));
        check("a_ready", 32'(a_ready), 32'(ma.st != 2'b10));
        check("a_axis",  32'(a_axis),  32'(ma.axis));
        check("a_count", 32'(a_count), 32'(exp_count(ma.trig)));
        check("b_state", 32'(b_state), 32'(mb.st));
        check("b_pulse", 32'(b_pulse), 32'(mb.st == 2'b10));
        check("b_ready", 32'(b_ready), 32'(mb.st != 2'b10));
        check("b_axis",  32'(b_axis),  32'(mb.axis));
        check("b_count", 32'(b_count), 32'(exp_count(mb.trig)));
    end

    task automatic drive(input logic v, input logic [1:0] x, input logic [1:0] y,
                         input logic [1:0] t);
        in_valid = v; in_x = x; in_y = y; in_t = t;
        @(negedge clk);
    endtask

    task automatic reset_step();
        reset = 1'b1;
        drive(1'b1, 2'd3, 2'd3, 2'd3);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        reset_step();
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_axis",  32'(a_axis),  32'd0);
        check("rst_pulse", 32'(a_pulse), 32'd0);

        // Basic trigger on x.
        repeat (3) drive(1'b1, 2'd2, 2'd0, 2'd0);
        check("basic_state", 32'(a_state), 32'd2);
        check("basic_pulse", 32'(a_pulse), 32'd1);
        check("basic_axis",  32'(a_axis),  32'd1);
        check("basic_count", 32'(a_count), 32'd1);
        check("basic_ready", 32'(a_ready), 32'd0);
        repeat (12) drive(1'b0, 2'd0, 2'd0, 2'd0);
        check("hold_state", 32'(a_state), 32'd3);
        drive(1'b1, 2'd1, 2'd0, 2'd0);
        check("hold_nonquiet", 32'(a_state), 32'd3);
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        check("hold_release", 32'(a_state), 32'd0);

        // Broken arming, then a trigger on y and t.
        drive(1'b1, 2'd0, 2'd3, 2'd0);
        drive(1'b1, 2'd0, 2'd3, 2'd0);
        check("arm_state", 32'(a_state), 32'd1);
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        check("broken_state", 32'(a_state), 32'd0);
        check("broken_count", 32'(a_count), 32'd1);
        drive(1'b1, 2'd2, 2'd0, 2'd0);
        drive(1'b1, 2'd0, 2'd2, 2'd0);
        drive(1'b1, 2'd0, 2'd2, 2'd3);
        check("yt_axis",  32'(a_axis),  32'd6);
        check("yt_count", 32'(a_count), 32'd2);

        // Continuous active samples through holdoff: no retrigger.
        repeat (20) drive(1'b1, 2'd3, 2'd3, 2'd3);
        check("cont_state", 32'(a_state), 32'd3);
        check("cont_count", 32'(a_count), 32'd2);
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        check("cont_release", 32'(a_state), 32'd0);

        // Reset during ARMING and during HOLDOFF.
        repeat (2) drive(1'b1, 2'd2, 2'd0, 2'd0);
        reset_step();
        check("rarm_state", 32'(a_state), 32'd0);
        check("rarm_count", 32'(a_count), 32'd0);
        check("rarm_axis",  32'(a_axis),  32'd0);
        check("rarm_pulse", 32'(a_pulse), 32'd0);
        repeat (6) drive(1'b1, 2'd2, 2'd0, 2'd0);
        check("pre_rhold_state", 32'(a_state), 32'd3);
        reset_step();
        check("rhold_state", 32'(a_state), 32'd0);
        check("rhold_count", 32'(a_count), 32'd0);
        check("rhold_axis",  32'(a_axis),  32'd0);
        check("rhold_pulse", 32'(a_pulse), 32'd0);

        // Edge thresholds: thr_hi=0 then thr_lo=0.
        thr_hi = 2'd0;
        drive(1'b1, 2'd0, 2'd0, 2'd0);
        check("hi0_b_pulse", 32'(b_pulse), 32'd1);
        check("hi0_b_axis",  32'(b_axis),  32'd7);
        check("hi0_a_state", 32'(a_state), 32'd1);
        thr_lo = 2'd0;
        repeat (30) drive(1'b1, 2'd0, 2'd0, 2'd0);
        check("lo0_a_state", 32'(a_state), 32'd3);
        check("lo0_b_state", 32'(b_state), 32'd3);
        check("lo0_a_count", 32'(a_count), 32'd1);

        // 256 triggers to reach the end of the counter.
        thr_hi = 2'd2;
        thr_lo = 2'd1;
        reset_step();
        repeat (256) begin
            repeat (3) drive(1'b1, 2'd3, 2'd0, 2'd0);
            repeat (12) drive(1'b1, 2'd0, 2'd0, 2'd0);
        end
`ifdef AVG_EVT_COUNT_SAT_EN
        check("end_a_count", 32'(a_count), 32'd255);
        check("end_b_count", 32'(b_count), 32'd255);
`else
        check("end_a_count", 32'(a_count), 32'd0);
        check("end_b_count", 32'(b_count), 32'd0);
`endif
        check("end_a_state", 32'(a_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avg_event_detector.md
AVG_EVENT_DETECTOR -- requirements
Module: avg_event_detector

Interface
REQ-001 Parameter ARM_COUNT, default 3, number of consecutive active accepted samples needed to trigger; legal range 1..15.
REQ-002 Parameter HOLDOFF_CYCLES, default 8, number of clk cycles of mandatory holdoff after a trigger; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  averaged sample present on in_x/in_y/in_t.
REQ-006 in_ready  output  1  detector accepts a sample this cycle.
REQ-007 in_x, in_y, in_t  input  2 each  moving-average window sums per axis, unsigned.
REQ-008 thr_hi  input  2  activity threshold; an axis is active when its value >= thr_hi.
REQ-009 thr_lo  input  2  quiet threshold; a sample is quiet when all three axes < thr_lo.
REQ-010 event_pulse  output  1  one-cycle trigger strobe.
REQ-011 event_axis  output  3  {t,y,x} active mask latched from the sample that completed arming.
REQ-012 event_count  output  8  number of triggers since reset.
REQ-013 state_o  output  2  current state: IDLE=00, ARMING=01, TRIGGERED=10, HOLDOFF=11.

Function
REQ-014 A sample is accepted on a rising edge where in_valid=1 and in_ready=1; in_ready=0 only in TRIGGERED, 1 in every other state.
REQ-015 "Active sample" = accepted sample with at least one axis >= thr_hi; thr_hi=0 makes every accepted sample active.
REQ-016 IDLE: active sample -> arm_cnt=1, next state ARMING, or TRIGGERED directly if ARM_COUNT=1; other samples or no sample -> stay.
REQ-017 ARMING: active sample -> arm_cnt+1, and TRIGGERED when the incremented value equals ARM_COUNT; accepted non-active sample -> IDLE, arm_cnt=0; no sample -> hold state and arm_cnt.
REQ-018 On the edge entering TRIGGERED: event_axis loads the active mask of the completing sample; event_count increments; holdoff counter loads HOLDOFF_CYCLES; arm_cnt clears.
REQ-019 event_pulse = 1 exactly in the single cycle state_o=TRIGGERED (the cycle after the completing sample's accepting edge); TRIGGERED always moves to HOLDOFF on the next edge.
REQ-020 HOLDOFF: holdoff counter decrements every clk regardless of in_valid, stopping at 0; samples accepted while counter > 0 are ignored.
REQ-021 HOLDOFF with counter=0: the first accepted quiet sample -> IDLE; non-quiet samples keep HOLDOFF; thr_lo=0 means no sample is quiet and the block stays in HOLDOFF until reset.
REQ-022 Latency: HOLDOFF lasts at least HOLDOFF_CYCLES+1 cycles; minimum spacing between two event_pulse assertions is HOLDOFF_CYCLES+2+ARM_COUNT cycles.
REQ-023 event_axis holds its value until the next trigger; thresholds are sampled combinationally at each accepting edge and may change at any time.
REQ-024 Every comparison is unsigned 2-bit; no arithmetic is performed on sample values.

Reset
REQ-025 Reset is synchronous, active-high, and has priority over all other events, including mid-ARMING and mid-HOLDOFF.
REQ-026 Reset values: state_o=IDLE, arm_cnt=0, holdoff counter=0, event_pulse=0, event_axis=000, event_count=0, in_ready=1.
REQ-027 A sample presented in the reset cycle is not accepted.

Configuration
REQ-028 Macro AVG_EVT_COUNT_SAT_EN defined: event_count saturates at 255 and further triggers leave it at 255.
REQ-029 Macro AVG_EVT_COUNT_SAT_EN undefined: event_count wraps from 255 to 0; trigger, pulse and state behaviour are identical in both builds.

Verification
REQ-030 Basic trigger: thr_hi=2, thr_lo=1, ARM_COUNT=3, HOLDOFF_CYCLES=8; valid samples x=2,y=0,t=0 on three consecutive edges -> event_pulse for 1 cycle, event_axis=001, event_count=1, state_o ends at 11.
REQ-031 Broken arming: active, active, then x=y=t=0 -> state_o returns to 00 with no pulse; three further active samples -> one pulse.
REQ-032 Holdoff: continuous active samples after a trigger -> no second pulse; in_ready=0 only during the TRIGGERED cycle; state_o stays 11 until a sample with all axes=0 arrives after counter expiry.
REQ-033 Reset mid-operation: reset asserted during ARMING (arm_cnt=2) and during HOLDOFF -> next cycle state_o=00, event_count=0, event_axis=000, no pulse.
REQ-034 Counter end: drive 256 triggers -> event_count=255 with AVG_EVT_COUNT_SAT_EN, 0 without.
REQ-035 Edge thresholds: thr_hi=0, ARM_COUNT=1 -> pulse on the cycle after the first valid sample; thr_lo=0 -> state_o remains 11 indefinitely.
